// File: rtl/op_f_pkg.sv
// op_f_pkg
// Shared types and constants for the op_f vector sequencer slice.
// Contents:
//   op_f_state_e          sequencer states (IDLE, SETTLE, CHECK, DONE)
//   VEC_COUNT/IDX_W/...   sizing constants for the 16-vector sweep
//   OP_F_EXP_*_DEFAULT    golden truth tables for the reference function
//                         (y = a^b^c^d, z = a&b&c&d)
//   sat_inc               saturating error-count increment
package op_f_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } op_f_state_e;

    localparam int VEC_COUNT = 16;
    localparam int IDX_W     = 4;
    localparam int ERR_W     = 5;
    localparam int SETTLE_W  = 4;

    localparam logic [VEC_COUNT-1:0] OP_F_EXP_Y_DEFAULT = 16'h6996;
    localparam logic [VEC_COUNT-1:0] OP_F_EXP_Z_DEFAULT = 16'h8000;

    // The count can never pass VEC_COUNT within one sweep; the clamp only
    // keeps the register honest if that ever changes.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        if (v >= ERR_W'(VEC_COUNT)) begin
            return v;
        end
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/op_f_vector_sequencer_lut.sv
// op_f_golden_lut
// Combinational golden truth table: maps a 4-bit input index {a,b,c,d}
// to the expected y/z responses. Reusable as a reference model.
// Parameters:
//   EXP_Y, EXP_Z  bit i is the expected output for index i
// Ports:
//   idx_i    in   4  vector index, a is the MSB
//   exp_y_o  out  1  expected y for idx_i
//   exp_z_o  out  1  expected z for idx_i
module op_f_golden_lut
    import op_f_pkg::*;
#(
    parameter logic [VEC_COUNT-1:0] EXP_Y = OP_F_EXP_Y_DEFAULT,
    parameter logic [VEC_COUNT-1:0] EXP_Z = OP_F_EXP_Z_DEFAULT
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic             exp_y_o,
    output logic             exp_z_o
);

    assign exp_y_o = EXP_Y[idx_i];
    assign exp_z_o = EXP_Z[idx_i];

endmodule

// File: rtl/op_f_vector_sequencer.sv
// op_f_vector_sequencer
// Self-running stimulus/response checker for the 4-input, 2-output
// function block. On start it walks indices 0..15 ({a,b,c,d}, a = MSB),
// holds each vector for max(SETTLE_CYCLES,1) cycles, samples y/z for one
// CHECK cycle against a golden table, and reports the mismatch count and
// the first failing index.
// Optional build macro:
//   OP_F_STOP_ON_ERR_EN  first mismatch ends the sweep immediately, with
//                        the failing vector left on the stimulus outputs.
// Ports:
//   clk              in   1  clock, rising edge
//   rst_n            in   1  asynchronous active-low reset
//   start            in   1  single-cycle sweep request (IDLE/DONE only)
//   dut_a..dut_d     out  1  stimulus bits 3..0 of the current index
//   dut_y, dut_z     in   1  responses from the function block
//   busy             out  1  sweep in progress
//   done             out  1  sweep complete, held until the next start
//   pass             out  1  valid with done, 1 iff err_count == 0
//   err_count        out  5  number of mismatching vectors
//   first_err_valid  out  1  at least one mismatch recorded
//   first_err_idx    out  4  index of the first mismatching vector
module op_f_vector_sequencer
    import op_f_pkg::*;
#(
    parameter int unsigned          SETTLE_CYCLES = 2,
    parameter logic [VEC_COUNT-1:0] EXP_Y         = OP_F_EXP_Y_DEFAULT,
    parameter logic [VEC_COUNT-1:0] EXP_Z         = OP_F_EXP_Z_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_c,
    output logic             dut_d,
    input  logic             dut_y,
    input  logic             dut_z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [IDX_W-1:0] first_err_idx
);

    // A zero settle time still spends one cycle in SETTLE, so the terminal
    // count is clamped at zero rather than wrapping.
    localparam logic [SETTLE_W-1:0] SETTLE_LAST =
        (SETTLE_CYCLES == 0) ? '0 : SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_COUNT - 1);

    op_f_state_e         state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [SETTLE_W-1:0] settle_cnt_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [ERR_W-1:0]    err_count_q;
    logic [ERR_W-1:0]    err_count_d;
    logic                first_err_valid_q;
    logic [IDX_W-1:0]    first_err_idx_q;

    logic                exp_y;
    logic                exp_z;
    logic                mismatch;

    op_f_golden_lut #(
        .EXP_Y (EXP_Y),
        .EXP_Z (EXP_Z)
    ) u_lut (
        .idx_i   (idx_q),
        .exp_y_o (exp_y),
        .exp_z_o (exp_z)
    );

    // Case inequality so an X/Z response is reported as a mismatch in
    // simulation; synthesis reduces it to an ordinary compare.
    assign mismatch    = (dut_y !== exp_y) || (dut_z !== exp_z);
    assign err_count_d = mismatch ? sat_inc(err_count_q) : err_count_q;

    // Sequencer. The stimulus is taken straight from idx_q, which only
    // changes on the edge that enters SETTLE, so the pins never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            idx_q             <= '0;
            settle_cnt_q      <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            err_count_q       <= '0;
            first_err_valid_q <= 1'b0;
            first_err_idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q           <= SETTLE;
                        idx_q             <= '0;
                        settle_cnt_q      <= '0;
                        busy_q            <= 1'b1;
                        done_q            <= 1'b0;
                        pass_q            <= 1'b0;
                        err_count_q       <= '0;
                        first_err_valid_q <= 1'b0;
                        first_err_idx_q   <= '0;
                    end
                end

                SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        settle_cnt_q <= '0;
                        state_q      <= CHECK;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end

                CHECK: begin
                    err_count_q <= err_count_d;
                    if (mismatch && !first_err_valid_q) begin
                        first_err_valid_q <= 1'b1;
                        first_err_idx_q   <= idx_q;
                    end
`ifdef OP_F_STOP_ON_ERR_EN
                    if (mismatch || (idx_q == IDX_LAST)) begin
`else
                    if (idx_q == IDX_LAST) begin
`endif
                        // idx_q is left untouched so the last (or failing)
                        // vector stays on the pins while DONE is held.
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_count_d == '0);
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= SETTLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dut_a           = idx_q[3];
    assign dut_b           = idx_q[2];
    assign dut_c           = idx_q[1];
    assign dut_d           = idx_q[0];
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_count_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_idx   = first_err_idx_q;

endmodule
